cv32e40p_pipe_stage_ft: RTL and testbench
=========================================

Name: cv32e40p_pipe_stage_ft

Overview:
- Generic, parametrised inter-stage pipeline register for the fault-tolerant cv32e40p, for use at the ID/EX boundary and other stage boundaries.
- Carries NUM_FIELDS independent fields of DATA_W bits under one valid/ready handshake.
- Adds an optional skid entry, per-field load gating, flush and hold.
- Adds optional TMR storage of the main entry, with majority voting, scrubbing and an error counter.

Parameters:
- DATA_W, 32, width of each field.
- NUM_FIELDS, 4, number of independently gated fields (channels).
- SKID_EN, 1, 1 = two-entry skid buffer with registered in_ready_o; 0 = single entry, combinational ready.
- TMR_EN, 1, 1 = main entry stored in three copies with majority vote; 0 = single copy.
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk_g  in  1  gated stage clock
- rst_n  in  1  async active-low reset
- flush_i  in  1  kill stage contents
- hold_i  in  1  freeze stage (multicycle/misaligned case)
- in_valid_i  in  1  upstream beat valid
- in_ready_o  out  1  stage can accept
- in_fld_en_i  in  NUM_FIELDS  per-field load enable for the beat
- in_data_i  in  NUM_FIELDS*DATA_W  field f at bits [f*DATA_W +: DATA_W]
- out_valid_o  out  1  downstream beat valid
- out_ready_i  in  1  downstream accepts
- out_data_o  out  NUM_FIELDS*DATA_W  registered (voted) fields
- err_o  out  1  TMR copy mismatch this cycle
- err_cnt_o  out  ERR_CNT_W  saturating count of mismatch cycles

Behaviour:
- Reset is asynchronous, active-low, on rst_n; the stage is clocked on clk_g.
- Reset values:
  - all data copies, the skid entry and the masks are 0;
  - main_v = 0, skid_v = 0;
  - out_valid_o = 0, err_o = 0, err_cnt_o = 0;
  - in_ready_o = 1 (when hold_i = 0).
  - Reset mid-transfer discards everything; no partial beat survives.
- States (SKID_EN = 1): EMPTY (main_v = 0), FULL (main_v = 1, skid_v = 0), SKID (main_v = 1, skid_v = 1).
- SKID_EN = 0: only EMPTY/FULL exist.
- Handshake signals:
  - acc = in_valid_i & in_ready_o;
  - out_fire = out_valid_o & out_ready_i.
- Outputs: out_valid_o = main_v & ~hold_i.
- in_ready_o:
  - SKID_EN = 1: ~skid_v & ~hold_i, with skid_v registered;
  - SKID_EN = 0: (~main_v | out_ready_i) & ~hold_i.
- Latency: an accepted beat appears on out_data_o/out_valid_o the next cycle. Throughput is 1 beat/cycle.
- Transitions (hold_i = 0, flush_i = 0):
  - EMPTY: acc -> load main, go FULL.
  - FULL:
    - acc & out_fire -> load main, stay FULL;
    - acc & ~out_fire -> capture beat and mask in skid, go SKID;
    - ~acc & out_fire -> EMPTY.
  - SKID: out_fire -> move skid to main (applying the stored mask), go FULL. There is no acceptance in SKID.
- Field gating:
  - On a main load, field f is written only if its enable bit is 1; otherwise the old value is kept. This holds for both direct and skid-to-main loads.
  - Enables of all zeros still form a valid beat (valid propagates, data unchanged).
- flush_i:
  - Takes effect next edge: main_v = 0, skid_v = 0.
  - Overrides acc, out_fire and hold_i; an incoming beat in the flush cycle is dropped.
  - Data registers are not cleared.
- hold_i:
  - No state change: no load, no skid move, no pop.
  - Data is retained; scrubbing continues.
  - out_valid_o and in_ready_o are forced to 0.
- TMR (TMR_EN = 1):
  - Main valid and data are stored in copies A/B/C.
  - Outputs use the bitwise majority of the three copies.
  - err_o = (A != B) | (B != C), including the valid bit; it is combinational from the registers.
  - Scrub: in any cycle without a main load, all copies are rewritten with the voted value. A load writes all copies with the new value.
  - err_cnt_o increments by 1 on each clock edge where err_o = 1, and saturates at all-ones.
- TMR_EN = 0: err_o = 0 and err_cnt_o = 0 (constant).
- The skid entry is never triplicated.

Test Plan:
- Streaming: in_valid_i = 1, out_ready_i = 1, data 0x1..0x10, all enables 1 -> out_data_o field0 = 0x1..0x10 one cycle later, no bubbles, in_ready_o stays 1.
- Backpressure:
  - Stimulus: send 0xA then 0xB, with out_ready_i = 0 during the second cycle.
  - Required response: state SKID, in_ready_o = 0.
  - Then raise out_ready_i: outputs 0xA then 0xB in order, nothing lost or duplicated.
- Field gating:
  - Preload all fields to 0x11111111.
  - Send a beat of 0x22222222 on every field, in_fld_en_i = 4'b0101.
  - Fields 0 and 2 read 0x22222222; fields 1 and 3 read 0x11111111.
- Flush and hold:
  - In SKID, assert flush_i together with in_valid_i -> next cycle out_valid_o = 0, in_ready_o = 1, dropped beat never emitted.
  - hold_i for 3 cycles in FULL -> out_valid_o = 0; after release the same data is presented.
- TMR fault injection:
  - Force copy B of field0 bit 5 flipped for one cycle.
  - Required response: out_data_o unchanged, err_o = 1 for that cycle, err_cnt_o = 1, copies equal again next cycle.
  - Repeat 300 times: err_cnt_o saturates at 255.
- Reset mid-operation: assert rst_n = 0 in SKID -> all outputs at reset values immediately (async), no beat emitted after release.

Source files
------------

// File: rtl/cv32e40p_pipe_stage_ft.sv
// cv32e40p_pipe_stage_ft: gated multi-field pipeline register with optional skid entry and TMR main entry
module cv32e40p_pipe_stage_ft #(
  parameter int DATA_W     = 32,
  parameter int NUM_FIELDS = 4,
  parameter int SKID_EN    = 1,
  parameter int TMR_EN     = 1,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                         clk_g,
  input  logic                         rst_n,
  input  logic                         flush_i,
  input  logic                         hold_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [NUM_FIELDS-1:0]        in_fld_en_i,
  input  logic [NUM_FIELDS*DATA_W-1:0] in_data_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [NUM_FIELDS*DATA_W-1:0] out_data_o,
  output logic                         err_o,
  output logic [ERR_CNT_W-1:0]         err_cnt_o
);
  localparam int W = NUM_FIELDS * DATA_W;
  // Main entry copies hold {valid, data}; every cycle all copies take ent_d, so non-load cycles scrub
  logic [W:0]            ent_a_q, ent_b_q, ent_c_q, vote, ent_d;
  logic [W-1:0]          skid_data_q, main_data, ld_src;
  logic [NUM_FIELDS-1:0] skid_mask_q, ld_mask;
  logic                  skid_v_q, skid_v_d, main_v, acc, out_fire, act;
  logic                  ld_in, ld_skid, to_skid, load;
  logic [ERR_CNT_W-1:0]  err_cnt_q;
  assign vote        = (TMR_EN != 0) ? ((ent_a_q & ent_b_q) | (ent_b_q & ent_c_q) | (ent_a_q & ent_c_q)) : ent_a_q;
  assign main_v      = vote[W];
  assign main_data   = vote[W-1:0];
  assign out_data_o  = main_data;
  assign out_valid_o = main_v & ~hold_i;
  assign in_ready_o  = (SKID_EN != 0) ? (~skid_v_q & ~hold_i) : ((~main_v | out_ready_i) & ~hold_i);
  assign acc         = in_valid_i & in_ready_o;
  assign out_fire    = out_valid_o & out_ready_i;
  assign act         = ~flush_i & ~hold_i;
  assign ld_skid     = act & skid_v_q & out_fire;
  assign ld_in       = act & acc & (~main_v | out_fire);
  assign to_skid     = (SKID_EN != 0) & act & acc & main_v & ~out_fire;
  assign load        = ld_in | ld_skid;
  assign ld_mask     = ld_skid ? skid_mask_q : in_fld_en_i;
  assign ld_src      = ld_skid ? skid_data_q : in_data_i;
  assign skid_v_d    = ~flush_i & (to_skid | (skid_v_q & ~ld_skid));
  assign err_o       = (TMR_EN != 0) & ((ent_a_q != ent_b_q) | (ent_b_q != ent_c_q));
  assign err_cnt_o   = err_cnt_q;
  always_comb begin
    ent_d    = '0;
    ent_d[W] = ~flush_i & (load | (main_v & ~out_fire));
    for (int f = 0; f < NUM_FIELDS; f++)
      ent_d[f*DATA_W +: DATA_W] = (load & ld_mask[f]) ? ld_src[f*DATA_W +: DATA_W] : main_data[f*DATA_W +: DATA_W];
  end
  always_ff @(posedge clk_g or negedge rst_n) begin
    if (!rst_n) begin
      ent_a_q     <= '0;
      ent_b_q     <= '0;
      ent_c_q     <= '0;
      skid_v_q    <= 1'b0;
      skid_data_q <= '0;
      skid_mask_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      ent_a_q  <= ent_d;
      skid_v_q <= skid_v_d;
      if (TMR_EN != 0) begin
        ent_b_q <= ent_d;
        ent_c_q <= ent_d;
      end
      if (to_skid) begin
        skid_data_q <= in_data_i;
        skid_mask_q <= in_fld_en_i;
      end
      if (err_o && !(&err_cnt_q)) err_cnt_q <= err_cnt_q + 1'b1;
    end
  end
endmodule

// File: tb/tb_cv32e40p_pipe_stage_ft.sv
// tb_cv32e40p_pipe_stage_ft: directed self-checking bench for the fault-tolerant pipe stage
module tb_cv32e40p_pipe_stage_ft;
  logic         clk_g = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush_i = 1'b0, hold_i = 1'b0;
  logic         in_valid_i = 1'b0, in_ready_o;
  logic [3:0]   in_fld_en_i = 4'hF;
  logic [127:0] in_data_i = '0;
  logic         out_valid_o, out_ready_i = 1'b0;
  logic [127:0] out_data_o;
  logic         err_o;
  logic [7:0]   err_cnt_o;
  int           total = 0, bad = 0;
  localparam logic [128:0] HOLD_ENT = {1'b0, {4{32'h5A}}};
  localparam logic [128:0] BAD_ENT  = HOLD_ENT ^ 129'h20;

  cv32e40p_pipe_stage_ft dut (
    .clk_g(clk_g), .rst_n(rst_n), .flush_i(flush_i), .hold_i(hold_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_fld_en_i(in_fld_en_i),
    .in_data_i(in_data_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_data_o(out_data_o), .err_o(err_o), .err_cnt_o(err_cnt_o)
  );

  always #5 clk_g = ~clk_g;

  task automatic chk(input string tag, input logic [128:0] got, input logic [128:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic put(input logic v, input logic [31:0] d, input logic [3:0] en);
    in_valid_i  = v;
    in_data_i   = {4{d}};
    in_fld_en_i = en;
  endtask

  initial begin
    #12;
    chk("rst_valid", out_valid_o, 0);
    chk("rst_ready", in_ready_o, 1);
    chk("rst_err", err_o, 0);
    chk("rst_cnt", err_cnt_o, 0);
    chk("rst_data", out_data_o, 0);
    @(negedge clk_g);
    rst_n = 1'b1;
    out_ready_i = 1'b1;
    put(1, 32'h1, 4'hF);
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk_g);
      chk("stream_valid", out_valid_o, 1);
      chk("stream_data", out_data_o, {4{i[31:0]}});
      chk("stream_ready", in_ready_o, 1);
      if (i < 16) put(1, i[31:0] + 1, 4'hF);
      else put(0, 0, 4'hF);
    end
    @(negedge clk_g);
    chk("stream_drain", out_valid_o, 0);
    put(1, 32'hA, 4'hF);
    @(negedge clk_g);
    chk("bp_a_data", out_data_o, {4{32'hA}});
    put(1, 32'hB, 4'hF);
    out_ready_i = 1'b0;
    @(negedge clk_g);
    chk("bp_skid_ready", in_ready_o, 0);
    chk("bp_skid_valid", out_valid_o, 1);
    chk("bp_skid_data", out_data_o, {4{32'hA}});
    put(0, 0, 4'hF);
    out_ready_i = 1'b1;
    @(negedge clk_g);
    chk("bp_b_valid", out_valid_o, 1);
    chk("bp_b_data", out_data_o, {4{32'hB}});
    chk("bp_b_ready", in_ready_o, 1);
    @(negedge clk_g);
    chk("bp_empty", out_valid_o, 0);
    put(1, 32'h11111111, 4'hF);
    @(negedge clk_g);
    put(1, 32'h22222222, 4'b0101);
    @(negedge clk_g);
    chk("gate_data", out_data_o, {32'h11111111, 32'h22222222, 32'h11111111, 32'h22222222});
    put(1, 32'h33333333, 4'b0000);
    @(negedge clk_g);
    chk("gate_zero_valid", out_valid_o, 1);
    chk("gate_zero_data", out_data_o, {32'h11111111, 32'h22222222, 32'h11111111, 32'h22222222});
    put(0, 0, 4'hF);
    @(negedge clk_g);
    chk("gate_drain", out_valid_o, 0);
    put(1, 32'hA5, 4'hF);
    out_ready_i = 1'b0;
    @(negedge clk_g);
    put(1, 32'hB6, 4'hF);
    @(negedge clk_g);
    chk("fl_skid_ready", in_ready_o, 0);
    put(1, 32'hC7, 4'hF);
    flush_i = 1'b1;
    @(negedge clk_g);
    chk("fl_valid", out_valid_o, 0);
    chk("fl_ready", in_ready_o, 1);
    flush_i = 1'b0;
    put(0, 0, 4'hF);
    out_ready_i = 1'b1;
    @(negedge clk_g);
    chk("fl_no_emit", out_valid_o, 0);
    put(1, 32'h5A, 4'hF);
    @(negedge clk_g);
    chk("hold_pre_valid", out_valid_o, 1);
    put(0, 0, 4'hF);
    hold_i = 1'b1;
    #1;
    chk("hold_valid", out_valid_o, 0);
    chk("hold_ready", in_ready_o, 0);
    repeat (3) begin
      @(negedge clk_g);
      chk("hold_cyc_valid", out_valid_o, 0);
      chk("hold_cyc_data", out_data_o, {4{32'h5A}});
    end
    hold_i = 1'b0;
    out_ready_i = 1'b0;
    #1;
    chk("hold_rel_valid", out_valid_o, 1);
    chk("hold_rel_data", out_data_o, {4{32'h5A}});
    @(negedge clk_g);
    out_ready_i = 1'b1;
    @(negedge clk_g);
    chk("hold_pop", out_valid_o, 0);
    force dut.ent_b_q = BAD_ENT;
    #1;
    chk("tmr_err", err_o, 1);
    chk("tmr_vote", out_data_o, {4{32'h5A}});
    release dut.ent_b_q;
    @(negedge clk_g);
    chk("tmr_err_clr", err_o, 0);
    chk("tmr_cnt1", err_cnt_o, 1);
    chk("tmr_scrub", dut.ent_b_q, HOLD_ENT);
    repeat (299) begin
      force dut.ent_b_q = BAD_ENT;
      #1;
      release dut.ent_b_q;
      @(negedge clk_g);
    end
    chk("tmr_sat", err_cnt_o, 255);
    chk("tmr_sat_err", err_o, 0);
    chk("tmr_sat_data", out_data_o, {4{32'h5A}});
    put(1, 32'h71, 4'hF);
    @(negedge clk_g);
    put(1, 32'h72, 4'hF);
    out_ready_i = 1'b0;
    @(negedge clk_g);
    chk("rm_skid_ready", in_ready_o, 0);
    put(0, 0, 4'hF);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rm_valid", out_valid_o, 0);
    chk("rm_ready", in_ready_o, 1);
    chk("rm_cnt", err_cnt_o, 0);
    chk("rm_data", out_data_o, 0);
    @(negedge clk_g);
    rst_n = 1'b1;
    out_ready_i = 1'b1;
    repeat (2) begin
      @(negedge clk_g);
      chk("rm_no_emit", out_valid_o, 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
